patch_transmitter: RTL and testbench

- Camera-side source for the patch synchronizer's per-camera patch interface.
- Accepts a raw stream of per-patch weighted sums from the camera pipeline and frames it.
- Emits one SOF marker, then patches 0..N_PATCH-1 tagged with patch_num, then one EOF marker, over a val/ack handshake.
- One instance per camera; the outputs connect directly to the synchronizer's patch_val/patch_ack/patch_numN/wtsumN.

---
 rtl/patch_transmitter_pkg.sv | 22 ++
 rtl/patch_transmitter_if.sv | 24 ++
 rtl/patch_transmitter_out_reg.sv | 38 +++
 rtl/patch_transmitter.sv | 126 ++++++++++++
 tb/tb_patch_transmitter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/patch_transmitter_pkg.sv
// Shared framing constants for the patch transmitter and the patch synchronizer:
// marker codes, FSM state encodings and the width helper.
package patch_transmitter_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SOF      = 3'd1;
    localparam logic [2:0] ST_PATCH    = 3'd2;
    localparam logic [2:0] ST_EOF_WAIT = 3'd3;
    localparam logic [2:0] ST_EOF      = 3'd4;

    // wtsum payload carried by a marker beat (patch_num = all ones)
    localparam int SOF_CODE = 1;
    localparam int EOF_CODE = 0;

    function automatic int log2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/patch_transmitter_if.sv
// Per-camera handshake bundle: raw wtsum input stream and the framed patch output.
// master = transmitter side, slave = camera pipeline plus synchronizer side.
interface patch_transmitter_if #(
    parameter int FP_SIZE = 32,
    parameter int PN_W    = 10
);
    logic               in_val;
    logic               in_ack;
    logic [FP_SIZE-1:0] wtsum_in;
    logic               patch_val;
    logic               patch_ack;
    logic [PN_W-1:0]    patch_num;
    logic [FP_SIZE-1:0] wtsum;

    modport master (
        input  in_val, wtsum_in, patch_ack,
        output in_ack, patch_val, patch_num, wtsum
    );

    modport slave (
        output in_val, wtsum_in, patch_ack,
        input  in_ack, patch_val, patch_num, wtsum
    );
endinterface

// File: rtl/patch_transmitter_out_reg.sv
// Single-entry val/ack output holding register: load wins over clear, otherwise holds.
// Payload is only rewritten on load, so it stays stable while val waits for ack.
module patch_transmitter_out_reg #(
    parameter int NUM_W = 10,
    parameter int DAT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DAT_W-1:0] dat_i,
    output logic             val_o,
    output logic [NUM_W-1:0] num_o,
    output logic [DAT_W-1:0] dat_o
);
    logic             val_q;
    logic [NUM_W-1:0] num_q;
    logic [DAT_W-1:0] dat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q <= 1'b0;
            num_q <= '1;
            dat_q <= '0;
        end else if (load_i) begin
            val_q <= 1'b1;
            num_q <= num_i;
            dat_q <= dat_i;
        end else if (clear_i) begin
            val_q <= 1'b0;
        end
    end

    assign val_o = val_q;
    assign num_o = num_q;
    assign dat_o = dat_q;
endmodule

// File: rtl/patch_transmitter.sv
// Frames a raw per-patch wtsum stream as SOF, patches 0..N_PATCH-1, EOF for the synchronizer.
// One-cycle input-to-output latency; input is acked only when the output register can take a beat.
module patch_transmitter
    import patch_transmitter_pkg::*;
#(
    parameter int FP_SIZE = 32,
    parameter int N_PATCH = 1000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                frame_start,
    patch_transmitter_if.master bus,
    output logic                busy,
    output logic                overrun,
    output logic [15:0]         frame_count
);
    localparam int              PN_W      = log2(N_PATCH);
    localparam logic [PN_W-1:0] NOT_PATCH = '1;
    localparam logic [PN_W-1:0] LAST_IDX  = PN_W'(N_PATCH - 1);

    logic [2:0]         state_q, state_d;
    logic [PN_W-1:0]    ctr_q, ctr_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        fcnt_q, fcnt_d;

    logic               ld, clr;
    logic [PN_W-1:0]    ld_num;
    logic [FP_SIZE-1:0] ld_dat;
    logic               in_ack, in_xfer, out_xfer;

    assign busy     = (state_q != ST_IDLE);
    assign out_xfer = bus.patch_val & bus.patch_ack;
    assign in_ack   = (state_q == ST_PATCH) & (~bus.patch_val | bus.patch_ack);
    assign in_xfer  = bus.in_val & in_ack;

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        fcnt_d    = fcnt_q;
        overrun_d = overrun_q | (frame_start & busy);
        ld        = 1'b0;
        clr       = 1'b0;
        ld_num    = NOT_PATCH;
        ld_dat    = '0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    ld      = 1'b1;
                    ld_dat  = FP_SIZE'(SOF_CODE);
                    state_d = ST_SOF;
                end
            end
            ST_SOF: begin
                if (out_xfer) begin
                    clr     = 1'b1;
                    ctr_d   = '0;
                    state_d = ST_PATCH;
                end
            end
            ST_PATCH: begin
                if (in_xfer) begin
                    ld     = 1'b1;
                    ld_num = ctr_q;
                    ld_dat = bus.wtsum_in;
                    // counter parks at 0 after the last patch so it can never alias NOT_PATCH
                    if (ctr_q == LAST_IDX) begin
                        ctr_d   = '0;
                        state_d = ST_EOF_WAIT;
                    end else begin
                        ctr_d = ctr_q + 1'b1;
                    end
                end else if (out_xfer) begin
                    clr = 1'b1;
                end
            end
            ST_EOF_WAIT: begin
                if (!bus.patch_val || out_xfer) begin
                    ld      = 1'b1;
                    ld_dat  = FP_SIZE'(EOF_CODE);
                    state_d = ST_EOF;
                end
            end
            ST_EOF: begin
                if (out_xfer) begin
                    clr     = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            ctr_q     <= '0;
            overrun_q <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            overrun_q <= overrun_d;
            fcnt_q    <= fcnt_d;
        end
    end

    patch_transmitter_out_reg #(
        .NUM_W (PN_W),
        .DAT_W (FP_SIZE)
    ) u_out_reg (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .load_i  (ld),
        .clear_i (clr),
        .num_i   (ld_num),
        .dat_i   (ld_dat),
        .val_o   (bus.patch_val),
        .num_o   (bus.patch_num),
        .dat_o   (bus.wtsum)
    );

    assign bus.in_ack  = in_ack;
    assign overrun     = overrun_q;
    assign frame_count = fcnt_q;
endmodule

// File: tb/tb_patch_transmitter.sv
// Directed bench for patch_transmitter with N_PATCH=5 (3-bit patch_num, marker code 7).
module tb_patch_transmitter;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        frame_start;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_count;

    always #5 CLK = ~CLK;

    patch_transmitter_if #(.FP_SIZE(32), .PN_W(3)) bus ();

    patch_transmitter #(
        .FP_SIZE (32),
        .N_PATCH (5)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .frame_start (frame_start),
        .bus         (bus),
        .busy        (busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          in_cnt;
    int          hold_viol;
    int          bubbles;
    logic [2:0]  got_num[$];
    logic [31:0] got_dat[$];
    int          got_cyc[$];
    logic        hv;
    logic [2:0]  hn;
    logic [31:0] hd;

    // Expected frame: SOF(7,1), patches (i,10+i) for i=0..4, EOF(7,0)
    function automatic int beat_errs();
        int          e;
        logic [2:0]  en;
        logic [31:0] ed;
        e = (got_num.size() > 7) ? got_num.size() - 7 : 7 - got_num.size();
        for (int i = 0; i < 7 && i < got_num.size(); i++) begin
            if (i == 0)      begin en = 3'd7; ed = 32'd1; end
            else if (i == 6) begin en = 3'd7; ed = 32'd0; end
            else             begin en = 3'(i - 1); ed = 32'(9 + i); end
            if (got_num[i] !== en || got_dat[i] !== ed) e++;
        end
        return e;
    endfunction

    // Called at a negedge: drive inputs for the coming posedge, then log what will transfer on it.
    task automatic cycle(input logic ack, input logic iv, input logic fs, input int n);
        bus.patch_ack = ack;
        bus.in_val    = iv;
        frame_start   = fs;
        bus.wtsum_in  = 32'(10 + in_cnt);
        #1;
        if (hv && !(bus.patch_val && bus.patch_num == hn && bus.wtsum == hd)) hold_viol++;
        hv = bus.patch_val && !bus.patch_ack;
        hn = bus.patch_num;
        hd = bus.wtsum;
        if (busy && !bus.patch_val) bubbles++;
        if (bus.patch_val && bus.patch_ack) begin
            got_num.push_back(bus.patch_num);
            got_dat.push_back(bus.wtsum);
            got_cyc.push_back(n);
        end
        if (bus.in_val && bus.in_ack) in_cnt++;
        @(negedge CLK);
    endtask

    task automatic run_frame(input bit ack_tog, input bit gap, input int ovr_at);
        bit fired;
        bit fs;
        got_num.delete();
        got_dat.delete();
        got_cyc.delete();
        in_cnt    = 0;
        hold_viol = 0;
        bubbles   = 0;
        hv        = 1'b0;
        fired     = 1'b0;
        for (int n = 0; n < 200 && got_num.size() < 7; n++) begin
            fs = (n == 0) || (ovr_at >= 0 && !fired && in_cnt == ovr_at && n > 0);
            if (fs && n > 0) fired = 1'b1;
            cycle(ack_tog ? (n % 2 == 0) : 1'b1, gap ? (n % 3 == 0) : 1'b1, fs, n);
        end
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++; if (bus.patch_val !== 1'b0) begin tests_failed++; $display("FAIL reset_patch_val got %b want 0", bus.patch_val); end
        tests_run++; if (bus.patch_num !== 3'd7) begin tests_failed++; $display("FAIL reset_patch_num got %0d want 7", bus.patch_num); end
        tests_run++; if (bus.wtsum !== 32'd0) begin tests_failed++; $display("FAIL reset_wtsum got %0d want 0", bus.wtsum); end
        tests_run++; if (bus.in_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ack got %b want 0", bus.in_ack); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", overrun); end
        tests_run++; if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    endtask

    task automatic test_basic();
        int e;
        run_frame(1'b0, 1'b0, -1);
        e = beat_errs();
        tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL basic_beats got %0d bad beats (%0d seen) want 0", e, got_num.size()); end
        if (got_cyc.size() == 7) begin
            tests_run++; if (got_cyc[5] - got_cyc[1] !== 4) begin tests_failed++; $display("FAIL basic_data_span got %0d cycles want 4", got_cyc[5] - got_cyc[1]); end
            tests_run++; if (got_cyc[6] - got_cyc[0] > 7) begin tests_failed++; $display("FAIL basic_frame_span got %0d cycles want <=7", got_cyc[6] - got_cyc[0]); end
        end
        tests_run++; if (frame_count !== 16'd1) begin tests_failed++; $display("FAIL basic_frame_count got %0d want 1", frame_count); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int e;
        run_frame(1'b1, 1'b0, -1);
        e = beat_errs();
        tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL bp_beats got %0d bad beats (%0d seen) want 0", e, got_num.size()); end
        tests_run++; if (hold_viol !== 0) begin tests_failed++; $display("FAIL bp_hold got %0d unstable cycles want 0", hold_viol); end
        tests_run++; if (in_cnt !== 5) begin tests_failed++; $display("FAIL bp_inputs got %0d accepted want 5", in_cnt); end
        tests_run++; if (frame_count !== 16'd2) begin tests_failed++; $display("FAIL bp_frame_count got %0d want 2", frame_count); end
    endtask

    task automatic test_gapped_input();
        int e;
        run_frame(1'b0, 1'b1, -1);
        e = beat_errs();
        tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL gap_beats got %0d bad beats (%0d seen) want 0", e, got_num.size()); end
        tests_run++; if (bubbles < 4) begin tests_failed++; $display("FAIL gap_bubbles got %0d want >=4", bubbles); end
        tests_run++; if (hold_viol !== 0) begin tests_failed++; $display("FAIL gap_hold got %0d unstable cycles want 0", hold_viol); end
        tests_run++; if (frame_count !== 16'd3) begin tests_failed++; $display("FAIL gap_frame_count got %0d want 3", frame_count); end
    endtask

    task automatic test_overrun();
        int e;
        run_frame(1'b0, 1'b0, 2);
        e = beat_errs();
        tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL ovr_beats got %0d bad beats (%0d seen) want 0", e, got_num.size()); end
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got %b want 1", overrun); end
        tests_run++; if (frame_count !== 16'd4) begin tests_failed++; $display("FAIL ovr_frame_count got %0d want 4", frame_count); end
        for (int n = 0; n < 4; n++) cycle(1'b1, 1'b1, 1'b0, n);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ovr_no_restart_busy got %b want 0", busy); end
        tests_run++; if (bus.patch_val !== 1'b0) begin tests_failed++; $display("FAIL ovr_no_restart_val got %b want 0", bus.patch_val); end
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        int e;
        got_num.delete(); got_dat.delete(); got_cyc.delete();
        in_cnt = 0; hv = 1'b0; found = 1'b0;
        cycle(1'b1, 1'b1, 1'b1, 0);
        for (int n = 1; n < 30 && !found; n++) begin
            cycle(1'b1, 1'b1, 1'b0, n);
            if (bus.patch_val && bus.patch_num == 3'd3) found = 1'b1;
        end
        tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_reach_patch3 got %b want 1", found); end
        bus.patch_ack = 1'b0;
        bus.in_val    = 1'b0;
        frame_start   = 1'b0;
        RESET         = 1'b1;
        @(negedge CLK);
        #1;
        tests_run++; if (bus.patch_val !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_patch_val got %b want 0", bus.patch_val); end
        tests_run++; if (bus.patch_num !== 3'd7) begin tests_failed++; $display("FAIL rst_mid_patch_num got %0d want 7", bus.patch_num); end
        tests_run++; if (bus.wtsum !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_wtsum got %0d want 0", bus.wtsum); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_overrun got %b want 0", overrun); end
        tests_run++; if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL rst_mid_frame_count got %0d want 0", frame_count); end
        RESET = 1'b0;
        @(negedge CLK);
        run_frame(1'b0, 1'b0, -1);
        e = beat_errs();
        tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL rst_mid_clean_frame got %0d bad beats (%0d seen) want 0", e, got_num.size()); end
        tests_run++; if (frame_count !== 16'd1) begin tests_failed++; $display("FAIL rst_mid_frame_count_after got %0d want 1", frame_count); end
    endtask

    task automatic test_back_to_back();
        int e;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        run_frame(1'b0, 1'b0, -1);
        e = beat_errs();
        tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL b2b_first got %0d bad beats want 0", e); end
        run_frame(1'b0, 1'b0, -1);
        e = beat_errs();
        tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL b2b_second got %0d bad beats (%0d seen) want 0", e, got_num.size()); end
        tests_run++; if (frame_count !== 16'd2) begin tests_failed++; $display("FAIL b2b_frame_count got %0d want 2", frame_count); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    endtask

    initial begin
        RESET         = 1'b1;
        frame_start   = 1'b0;
        bus.in_val    = 1'b0;
        bus.patch_ack = 1'b0;
        bus.wtsum_in  = 32'd0;
        hv            = 1'b0;
        in_cnt        = 0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;
        test_reset();
        @(negedge CLK);
        test_basic();
        test_backpressure();
        test_gapped_input();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
